comparator_ctrl: RTL and testbench
==================================

COMPARATOR_CTRL -- requirements
Module: comparator_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- CRC_KEY_WIDTH, 4, task ID width.
- CRC_KEY_SIZE, 16, number of tasks.
- CRC_RAM_ADDRESS_WIDTH, 10, fingerprint RAM address width.
- FPRINT_WIDTH, 32, fingerprint word width.
- MAX_COMPARES, 512, per-task compare bound.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- fprints_ready, in, CRC_KEY_SIZE, per-task both-cores-ready flags.
- head0_matches_head1, in, 1, head pointer equality flag.
- tail0_matches_head0, in, 1, core 0 tail-at-head flag.
- tail1_matches_head1, in, 1, core 1 tail-at-head flag.
- comp_tail_pointer0, in, CRC_RAM_ADDRESS_WIDTH, core 0 tail for comp_task.
- comp_tail_pointer1, in, CRC_RAM_ADDRESS_WIDTH, core 1 tail for comp_task.
- comp_task, out, CRC_KEY_WIDTH, task under comparison.
- comp_increment_tail_pointer, out, 1, one-cycle tail advance pulse.
- comp_reset_fprint_ready, out, 1, clear-ready request (level).
- comp_mismatch_detected, out, 1, qualifies the clear request as a fault.
- reset_fprint_ack, in, 1, clear-ready acknowledge.
- ram_addr, out, CRC_RAM_ADDRESS_WIDTH, fingerprint RAM read address.
- ram_rd_data, in, FPRINT_WIDTH, RAM data, 1-cycle read latency.
- result_valid, out, 1, one-cycle completion pulse.
- result_task, out, CRC_KEY_WIDTH, completed task.
- result_mismatch, out, 1, 1 = fault on result_task.

Function
REQ-003 SHALL implement the FSM: IDLE, SELECT, WAIT_PTR, CHECK, READ0, READ1, COMPARE, INCR, CLEAR_REQ, DONE.
REQ-004 IDLE -> SELECT SHALL occur when fprints_ready != 0.
REQ-005 SELECT SHALL latch comp_task round-robin: first set bit searching upward from last_task+1, wrapping at CRC_KEY_SIZE-1 -> 0.
REQ-006 SELECT SHALL update last_task to the chosen task and clear the compare counter.
REQ-007 WAIT_PTR SHALL last exactly 1 cycle, then go to CHECK; it covers the registered pointer/flag update after a comp_task change or tail increment.
REQ-008 CHECK SHALL branch as follows:
- tail0_matches_head0 & tail1_matches_head1 -> CLEAR_REQ, mismatch=0 (all pairs equal).
- Exactly one of the two flags set -> CLEAR_REQ, mismatch=1 (count imbalance).
- Otherwise -> READ0.
REQ-009 READ0 SHALL drive ram_addr=comp_tail_pointer0; READ1 SHALL drive ram_addr=comp_tail_pointer1 and capture ram_rd_data as fp0; COMPARE SHALL capture ram_rd_data as fp1.
REQ-010 COMPARE SHALL go to CLEAR_REQ with mismatch=1 when fp0 != fp1; otherwise to INCR.
REQ-011 INCR SHALL assert comp_increment_tail_pointer for exactly one cycle and increment the compare counter, then go to WAIT_PTR.
REQ-012 When the counter reaches MAX_COMPARES in INCR, the FSM SHALL go to CLEAR_REQ with mismatch=1 (livelock guard).
REQ-013 In CLEAR_REQ, comp_reset_fprint_ready and comp_mismatch_detected(=mismatch) SHALL be held until reset_fprint_ack is sampled high, then the FSM goes to DONE; both outputs SHALL be low in DONE.
REQ-014 DONE SHALL pulse result_valid for 1 cycle, with result_task=comp_task and result_mismatch=mismatch, then go to IDLE.
REQ-015 comp_task SHALL be stable from SELECT through DONE.
REQ-016 All outputs SHALL be registered or decoded from state only; ram_addr SHALL be 0 outside READ0/READ1.
REQ-017 fprints_ready changes during a comparison SHALL NOT affect the task in progress.
REQ-018 reset_fprint_ack outside CLEAR_REQ SHALL be ignored.

Reset
REQ-019 reset low SHALL asynchronously force state=IDLE, comp_task=0, last_task=CRC_KEY_SIZE-1, counter=0, fp0=fp1=0, mismatch=0, and all outputs 0.
REQ-020 Reset asserted mid-comparison SHALL abandon the comparison with no result_valid pulse; the FSM restarts from IDLE.

Structure
REQ-021 CRC_KEY_WIDTH, CRC_KEY_SIZE, CRC_RAM_ADDRESS_WIDTH and FPRINT_WIDTH SHALL come from the shared crc_defines package; state encodings SHALL be local.
REQ-022 Round-robin selection SHALL be one sub-module, rr_task_arbiter (request vector, last_task in; grant ID, grant_valid out).

Verification
REQ-023 Task 3 ready, tails 0/100, heads 2/102, RAM words equal -> 2 increment pulses, one clear request with mismatch=0, result_valid with task=3, mismatch=0.
REQ-024 Same setup with second core-1 word 0xDEADBEEF vs core-0 0x12345678 -> 1 increment, clear request with comp_mismatch_detected=1, result_mismatch=1.
REQ-025 tail0 reaches head0 while tail1 != head1 -> mismatch=1 with no further RAM reads.
REQ-026 fprints_ready=0x8001 with last_task=0 -> task 15 served before task 0; a second pass serves task 0.
REQ-027 reset_fprint_ack delayed 5 cycles -> request held 5 cycles, dropped the cycle after ack; reset asserted in READ1 -> all outputs 0 immediately, no result_valid.

Source files
------------

// File: rtl/crc_defines.sv
// Shared fingerprint-checking constants.
// Holds the task-ID, task-count, fingerprint RAM address and fingerprint
// word widths used by every block that touches the fingerprint store,
// plus the default bound on compares per task.
package crc_defines;

    localparam int CRC_KEY_WIDTH         = 4;
    localparam int CRC_KEY_SIZE          = 16;
    localparam int CRC_RAM_ADDRESS_WIDTH = 10;
    localparam int FPRINT_WIDTH          = 32;
    localparam int MAX_COMPARES          = 512;

endpackage : crc_defines

// File: rtl/rr_task_arbiter.sv
// Round-robin task picker.
// Ports:
//   i_req         - per-task request vector (fingerprints ready on both cores)
//   i_last_task   - task served most recently; search starts just above it
//   o_grant       - ID of the first requesting task found searching upward
//                   from i_last_task+1, wrapping at CRC_KEY_SIZE-1 -> 0
//   o_grant_valid - at least one request is set
// Purely combinational; the caller registers the grant.
module rr_task_arbiter
    import crc_defines::*;
#(
    parameter int CRC_KEY_WIDTH = crc_defines::CRC_KEY_WIDTH,
    parameter int CRC_KEY_SIZE  = crc_defines::CRC_KEY_SIZE
) (
    input  logic [CRC_KEY_SIZE-1:0]  i_req,
    input  logic [CRC_KEY_WIDTH-1:0] i_last_task,
    output logic [CRC_KEY_WIDTH-1:0] o_grant,
    output logic                     o_grant_valid
);

    int w_idx;

    // Scan all tasks once, starting one above the last served task; the last
    // candidate visited is i_last_task itself, so a lone requester always wins.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        for (int i = 1; i <= CRC_KEY_SIZE; i++) begin
            w_idx = (int'(i_last_task) + i) % CRC_KEY_SIZE;
            if (!o_grant_valid && i_req[w_idx]) begin
                o_grant       = CRC_KEY_WIDTH'(w_idx);
                o_grant_valid = 1'b1;
            end else begin
                o_grant       = o_grant;
                o_grant_valid = o_grant_valid;
            end
        end
    end

endmodule : rr_task_arbiter

// File: rtl/comparator_ctrl.sv
// Dual-core fingerprint comparison controller.
// Picks a task whose fingerprints are ready on both cores (round robin),
// walks both cores' fingerprint queues pairwise from tail to head, compares
// each pair out of the fingerprint RAM, and reports the task as clean or
// faulty after the upstream ready flag has been cleared.
// Ports:
//   clk, reset (async, active low)
//   fprints_ready                 - per-task both-cores-ready flags
//   head0_matches_head1           - head pointer equality (informational)
//   tail0/1_matches_head0/1       - per-core "queue drained" flags for comp_task
//   comp_tail_pointer0/1          - per-core tail pointers for comp_task
//   comp_task                     - task under comparison
//   comp_increment_tail_pointer   - one-cycle pulse: advance both tails
//   comp_reset_fprint_ready       - clear-ready request, held until ack
//   comp_mismatch_detected        - marks the clear request as a fault
//   reset_fprint_ack              - clear-ready acknowledge
//   ram_addr / ram_rd_data        - fingerprint RAM port, 1-cycle read latency
//   result_valid/task/mismatch    - one-cycle completion report
// All outputs are registers loaded from the next-state decode.
module comparator_ctrl
    import crc_defines::*;
#(
    parameter int CRC_KEY_WIDTH         = crc_defines::CRC_KEY_WIDTH,
    parameter int CRC_KEY_SIZE          = crc_defines::CRC_KEY_SIZE,
    parameter int CRC_RAM_ADDRESS_WIDTH = crc_defines::CRC_RAM_ADDRESS_WIDTH,
    parameter int FPRINT_WIDTH          = crc_defines::FPRINT_WIDTH,
    parameter int MAX_COMPARES          = crc_defines::MAX_COMPARES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CRC_KEY_SIZE-1:0]          fprints_ready,
    input  logic                             head0_matches_head1,
    input  logic                             tail0_matches_head0,
    input  logic                             tail1_matches_head1,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer0,
    input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer1,
    output logic [CRC_KEY_WIDTH-1:0]         comp_task,
    output logic                             comp_increment_tail_pointer,
    output logic                             comp_reset_fprint_ready,
    output logic                             comp_mismatch_detected,
    input  logic                             reset_fprint_ack,
    output logic [CRC_RAM_ADDRESS_WIDTH-1:0] ram_addr,
    input  logic [FPRINT_WIDTH-1:0]          ram_rd_data,
    output logic                             result_valid,
    output logic [CRC_KEY_WIDTH-1:0]         result_task,
    output logic                             result_mismatch
);

    localparam int CNT_W = $clog2(MAX_COMPARES + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SELECT    = 4'd1,
        S_WAIT_PTR  = 4'd2,
        S_CHECK     = 4'd3,
        S_READ0     = 4'd4,
        S_READ1     = 4'd5,
        S_COMPARE   = 4'd6,
        S_INCR      = 4'd7,
        S_CLEAR_REQ = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t                           r_state, w_state_nxt;
    logic [CRC_KEY_WIDTH-1:0]         r_comp_task, w_task_nxt;
    logic [CRC_KEY_WIDTH-1:0]         r_last_task, w_last_nxt;
    logic [CNT_W-1:0]                 r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [FPRINT_WIDTH-1:0]          r_fp0, w_fp0_nxt;
    logic [FPRINT_WIDTH-1:0]          r_fp1, w_fp1_nxt;
    logic                             r_mismatch, w_mis_nxt;

    logic                             r_inc;
    logic                             r_clr;
    logic                             r_mis_det;
    logic [CRC_RAM_ADDRESS_WIDTH-1:0] r_ram_addr;
    logic                             r_res_valid;
    logic [CRC_KEY_WIDTH-1:0]         r_res_task;
    logic                             r_res_mis;

    logic [CRC_KEY_WIDTH-1:0]         w_grant;
    logic                             w_grant_valid;
    logic                             w_unused;

    // Head equality is not needed for the decision (the per-core tail flags
    // already say everything), and fp1 is kept only as a debug capture.
    assign w_unused = ^{head0_matches_head1, r_fp1};

    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    rr_task_arbiter #(
        .CRC_KEY_WIDTH (CRC_KEY_WIDTH),
        .CRC_KEY_SIZE  (CRC_KEY_SIZE)
    ) u_arb (
        .i_req         (fprints_ready),
        .i_last_task   (r_last_task),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Next-state and datapath-next decode.
    always_comb begin
        w_state_nxt = r_state;
        w_task_nxt  = r_comp_task;
        w_last_nxt  = r_last_task;
        w_cnt_nxt   = r_cnt;
        w_fp0_nxt   = r_fp0;
        w_fp1_nxt   = r_fp1;
        w_mis_nxt   = r_mismatch;
        case (r_state)
            S_IDLE: begin
                // The task is latched on entry to SELECT so comp_task is
                // already stable for the whole of SELECT.
                if (w_grant_valid) begin
                    w_state_nxt = S_SELECT;
                    w_task_nxt  = w_grant;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SELECT: begin
                w_last_nxt  = r_comp_task;
                w_cnt_nxt   = '0;
                w_mis_nxt   = 1'b0;
                w_state_nxt = S_WAIT_PTR;
            end
            S_WAIT_PTR: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (tail0_matches_head0 && tail1_matches_head1) begin
                    w_state_nxt = S_CLEAR_REQ;
                    w_mis_nxt   = 1'b0;
                end else if (tail0_matches_head0 ^ tail1_matches_head1) begin
                    // One core ran out of fingerprints before the other.
                    w_state_nxt = S_CLEAR_REQ;
                    w_mis_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_READ0;
                end
            end
            S_READ0: begin
                w_state_nxt = S_READ1;
            end
            S_READ1: begin
                w_fp0_nxt   = ram_rd_data;
                w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                // Core-1 word arrives this cycle; compare it directly rather
                // than waiting a cycle for the fp1 capture.
                w_fp1_nxt = ram_rd_data;
                if (r_fp0 != ram_rd_data) begin
                    w_state_nxt = S_CLEAR_REQ;
                    w_mis_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_INCR;
                end
            end
            S_INCR: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CNT_W'(MAX_COMPARES)) begin
                    // Queues that never drain indicate a stuck producer.
                    w_state_nxt = S_CLEAR_REQ;
                    w_mis_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_PTR;
                end
            end
            S_CLEAR_REQ: begin
                if (reset_fprint_ack) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CLEAR_REQ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the next state
    // so they line up cycle-for-cycle with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_comp_task <= '0;
            r_last_task <= CRC_KEY_WIDTH'(CRC_KEY_SIZE - 1);
            r_cnt       <= '0;
            r_fp0       <= '0;
            r_fp1       <= '0;
            r_mismatch  <= 1'b0;
            r_inc       <= 1'b0;
            r_clr       <= 1'b0;
            r_mis_det   <= 1'b0;
            r_ram_addr  <= '0;
            r_res_valid <= 1'b0;
            r_res_task  <= '0;
            r_res_mis   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_comp_task <= w_task_nxt;
            r_last_task <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fp0       <= w_fp0_nxt;
            r_fp1       <= w_fp1_nxt;
            r_mismatch  <= w_mis_nxt;
            r_inc       <= (w_state_nxt == S_INCR);
            r_clr       <= (w_state_nxt == S_CLEAR_REQ);
            r_mis_det   <= (w_state_nxt == S_CLEAR_REQ) && w_mis_nxt;
            r_res_valid <= (w_state_nxt == S_DONE);
            r_res_task  <= (w_state_nxt == S_DONE) ? w_task_nxt : '0;
            r_res_mis   <= (w_state_nxt == S_DONE) && w_mis_nxt;
            case (w_state_nxt)
                S_READ0: r_ram_addr <= comp_tail_pointer0;
                S_READ1: r_ram_addr <= comp_tail_pointer1;
                default: r_ram_addr <= '0;
            endcase
        end
    end

    assign comp_task                   = r_comp_task;
    assign comp_increment_tail_pointer = r_inc;
    assign comp_reset_fprint_ready     = r_clr;
    assign comp_mismatch_detected      = r_mis_det;
    assign ram_addr                    = r_ram_addr;
    assign result_valid                = r_res_valid;
    assign result_task                 = r_res_task;
    assign result_mismatch             = r_res_mis;

endmodule : comparator_ctrl

// File: tb/tb_comparator_ctrl.sv
// Scoreboard bench for comparator_ctrl: directed scenarios push expected
// completion records; an independent monitor pops them on result_valid.
module tb_comparator_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] fprints_ready;
    logic        head0_matches_head1;
    logic        tail0_matches_head0;
    logic        tail1_matches_head1;
    logic [9:0]  comp_tail_pointer0;
    logic [9:0]  comp_tail_pointer1;
    logic [3:0]  comp_task;
    logic        comp_increment_tail_pointer;
    logic        comp_reset_fprint_ready;
    logic        comp_mismatch_detected;
    logic        reset_fprint_ack;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rd_data;
    logic        result_valid;
    logic [3:0]  result_task;
    logic        result_mismatch;

    comparator_ctrl dut (
        .clk                         (clk),
        .reset                       (reset),
        .fprints_ready               (fprints_ready),
        .head0_matches_head1         (head0_matches_head1),
        .tail0_matches_head0         (tail0_matches_head0),
        .tail1_matches_head1         (tail1_matches_head1),
        .comp_tail_pointer0          (comp_tail_pointer0),
        .comp_tail_pointer1          (comp_tail_pointer1),
        .comp_task                   (comp_task),
        .comp_increment_tail_pointer (comp_increment_tail_pointer),
        .comp_reset_fprint_ready     (comp_reset_fprint_ready),
        .comp_mismatch_detected      (comp_mismatch_detected),
        .reset_fprint_ack            (reset_fprint_ack),
        .ram_addr                    (ram_addr),
        .ram_rd_data                 (ram_rd_data),
        .result_valid                (result_valid),
        .result_task                 (result_task),
        .result_mismatch             (result_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tsk;
        int mis;
        int incs;
        int reads;
        int clr_cycles;
        int clr_mis;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [31:0] mem [1024];
    logic [9:0]  base0 [16];
    logic [9:0]  base1 [16];
    logic [9:0]  head0 [16];
    logic [9:0]  head1 [16];
    logic [9:0]  off   [16];

    logic [15:0] req_mask = 16'h0000;
    int          req_seq = 0;
    int          seen_seq;
    int          ack_delay = 1;
    int          clr_seen;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Fingerprint RAM with one cycle of read latency.
    always @(posedge clk) ram_rd_data <= mem[ram_addr];

    // Upstream pointer unit: registered tail pointers/flags for comp_task.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) off[i] <= 10'd0;
            comp_tail_pointer0  <= 10'd0;
            comp_tail_pointer1  <= 10'd0;
            tail0_matches_head0 <= 1'b0;
            tail1_matches_head1 <= 1'b0;
            head0_matches_head1 <= 1'b0;
        end else begin
            if (comp_increment_tail_pointer) off[comp_task] <= off[comp_task] + 10'd1;
            if (result_valid) off[result_task] <= 10'd0;
            comp_tail_pointer0  <= base0[comp_task] + off[comp_task];
            comp_tail_pointer1  <= base1[comp_task] + off[comp_task];
            tail0_matches_head0 <= (base0[comp_task] + off[comp_task]) == head0[comp_task];
            tail1_matches_head1 <= (base1[comp_task] + off[comp_task]) == head1[comp_task];
            head0_matches_head1 <= head0[comp_task] == head1[comp_task];
        end
    end

    // Ready flags and clear-ready acknowledge, updated on the falling edge.
    always @(negedge clk) begin
        logic [15:0] nxt;
        nxt = fprints_ready;
        if (!reset) begin
            fprints_ready    <= 16'h0000;
            reset_fprint_ack <= 1'b0;
            clr_seen         <= 0;
            seen_seq         <= req_seq;
        end else begin
            if (req_seq != seen_seq) begin
                nxt = nxt | req_mask;
                seen_seq <= req_seq;
            end
            if (comp_reset_fprint_ready && !reset_fprint_ack) begin
                if (clr_seen + 1 >= ack_delay) begin
                    reset_fprint_ack <= 1'b1;
                    nxt[comp_task] = 1'b0;
                end
                clr_seen <= clr_seen + 1;
            end else if (!comp_reset_fprint_ready) begin
                reset_fprint_ack <= 1'b0;
                clr_seen <= 0;
            end
            fprints_ready <= nxt;
        end
    end

    // Monitor: accumulate per-comparison activity and check on completion.
    initial begin
        int   inc_c = 0, rd_c = 0, clr_c = 0, clr_m = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                inc_c = 0; rd_c = 0; clr_c = 0; clr_m = 0;
            end else begin
                if (comp_increment_tail_pointer) inc_c++;
                if (ram_addr != 10'd0) rd_c++;
                if (comp_reset_fprint_ready) begin
                    clr_c++;
                    clr_m = int'(comp_mismatch_detected);
                end
                if (result_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: actual task %0d, required no result", result_task);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_task", int'(result_task), e.tsk);
                        chk("result_mismatch", int'(result_mismatch), e.mis);
                        chk("incr_pulses", inc_c, e.incs);
                        chk("ram_reads_nonzero", rd_c, e.reads);
                        chk("clear_req_cycles", clr_c, e.clr_cycles);
                        chk("clear_req_mismatch", clr_m, e.clr_mis);
                    end
                    inc_c = 0; rd_c = 0; clr_c = 0; clr_m = 0;
                end
            end
        end
    end

    task automatic issue(input logic [15:0] mask);
        req_mask = mask;
        req_seq++;
    endtask

    task automatic expect_res(input int t, input int m, input int incs,
                              input int reads, input int clrc);
        exp_t e;
        e.tsk = t; e.mis = m; e.incs = incs; e.reads = reads;
        e.clr_cycles = clrc; e.clr_mis = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout_pending"}, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic set_task(input int t, input int b0, input int b1,
                            input int h0, input int h1);
        base0[t] = 10'(b0); base1[t] = 10'(b1);
        head0[t] = 10'(h0); head1[t] = 10'(h1);
    endtask

    function automatic int outs_or();
        return int'({comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready,
                     comp_mismatch_detected, ram_addr, result_valid, result_task,
                     result_mismatch});
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
        for (int i = 0; i < 16; i++) set_task(i, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_or(), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", outs_or(), 0);

        // Task 3: two equal pairs, then both queues drain.
        set_task(3, 0, 100, 2, 102);
        mem[0] = 32'hA5A5_0001; mem[100] = 32'hA5A5_0001;
        mem[1] = 32'h0BAD_F00D; mem[101] = 32'h0BAD_F00D;
        expect_res(3, 0, 2, 3, 1);
        issue(16'h0008);
        wait_drain("equal_pairs");

        // Task 3 again: second pair differs.
        mem[1] = 32'h1234_5678; mem[101] = 32'hDEAD_BEEF;
        expect_res(3, 1, 1, 3, 1);
        issue(16'h0008);
        wait_drain("word_mismatch");

        // Task 0: core 0 drained, core 1 not -> imbalance, no RAM reads.
        set_task(0, 5, 105, 5, 107);
        expect_res(0, 1, 0, 0, 1);
        issue(16'h0001);
        wait_drain("count_imbalance");

        // Tasks 15 and 0 both ready with last task 0: 15 first, then 0.
        set_task(0, 5, 105, 5, 105);
        set_task(15, 7, 300, 7, 300);
        expect_res(15, 0, 0, 0, 1);
        expect_res(0, 0, 0, 0, 1);
        issue(16'h8001);
        wait_drain("round_robin");

        // Task 9 with a slow acknowledge: request held five cycles.
        set_task(9, 20, 400, 20, 400);
        ack_delay = 5;
        expect_res(9, 0, 0, 0, 5);
        issue(16'h0200);
        wait_drain("slow_ack");
        ack_delay = 1;

        // Task 5: reset while the core-1 word is being addressed.
        set_task(5, 10, 200, 12, 202);
        mem[10] = 32'hC0DE_0010; mem[200] = 32'hC0DE_0010;
        mem[11] = 32'hC0DE_0011; mem[201] = 32'hC0DE_0011;
        issue(16'h0020);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (ram_addr == 10'd200) found = 1'b1;
        end
        chk("reached_read1", int'(found), 1);
        #1 reset = 1'b0;
        #1 chk("reset_mid_outputs", outs_or(), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Task 5 again after reset runs to completion from a fresh start.
        expect_res(5, 0, 2, 4, 1);
        issue(16'h0020);
        wait_drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_comparator_ctrl
